// File: rtl/data_stack_pkg.sv
// Shared definitions for the Forth data stack: opcode encoding and the
// minimum stack depth each opcode needs before it may execute.
package data_stack_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_PUSH   = 3'd1;
    localparam logic [2:0] OP_DROP   = 3'd2;
    localparam logic [2:0] OP_UNARY  = 3'd3;
    localparam logic [2:0] OP_BINARY = 3'd4;
    localparam logic [2:0] OP_DUP    = 3'd5;
    localparam logic [2:0] OP_SWAP   = 3'd6;
    localparam logic [2:0] OP_OVER   = 3'd7;

    function automatic logic [1:0] min_depth(input logic [2:0] op);
        logic [1:0] need;
        need = 2'd0;
        case (op)
            OP_NOP, OP_PUSH:              need = 2'd0;
            OP_DROP, OP_UNARY, OP_DUP:    need = 2'd1;
            OP_BINARY, OP_SWAP, OP_OVER:  need = 2'd2;
            default:                      need = 2'd0;
        endcase
        return need;
    endfunction

    // Push-class ops grow the stack by one and are blocked when full.
    function automatic logic is_push_op(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

endpackage

// File: rtl/stack_spill_ram.sv
// Spill storage below the T/Y registers: synchronous write, asynchronous read.
module stack_spill_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// Forth data stack: T and Y held in registers for the ALU, deeper items
// spilled to a small RAM. One stack operation per clock.
import data_stack_pkg::*;

module data_stack #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            stackOp,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] T,
    output logic [DATA_WIDTH-1:0] Y,
    output logic [PTR_WIDTH+1:0]  depth,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH+1:0] CAPACITY = (PTR_WIDTH+2)'(DEPTH + 2);
    localparam logic [PTR_WIDTH+1:0] DEPTH_ONE = (PTR_WIDTH+2)'(1);
    localparam logic [PTR_WIDTH+1:0] DEPTH_TWO = (PTR_WIDTH+2)'(2);
    localparam logic [PTR_WIDTH:0]   SP_ONE    = (PTR_WIDTH+1)'(1);

    logic [PTR_WIDTH:0]    sp;
    logic [PTR_WIDTH:0]    sp_below;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] refill;

    logic [PTR_WIDTH+1:0]  need;
    logic                  under_err;
    logic                  over_err;
    logic                  op_ok;

    logic [DATA_WIDTH-1:0] t_next;
    logic [DATA_WIDTH-1:0] y_next;
    logic [PTR_WIDTH+1:0]  depth_next;
    logic [PTR_WIDTH:0]    sp_next;
    logic                  spill_we;

    assign sp_below = sp - SP_ONE;
    assign refill   = (depth > DEPTH_TWO) ? ram_rdata : '0;
    assign empty    = (depth == '0);
    assign full     = (depth == CAPACITY);

    stack_spill_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_spill_ram (
        .clk   (clk),
        .we    (spill_we),
        .waddr (sp[PTR_WIDTH-1:0]),
        .wdata (Y),
        .raddr (sp_below[PTR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    // Underflow takes priority; an erroring op leaves every piece of state alone.
    always_comb begin
        need      = {{PTR_WIDTH{1'b0}}, min_depth(stackOp)};
        under_err = (depth < need);
        over_err  = !under_err && is_push_op(stackOp) && full;
        op_ok     = !under_err && !over_err;

        t_next     = T;
        y_next     = Y;
        depth_next = depth;
        sp_next    = sp;
        spill_we   = 1'b0;

        case (stackOp)
            OP_PUSH, OP_DUP, OP_OVER: begin
                if (stackOp == OP_PUSH) begin
                    t_next = din;
                end else if (stackOp == OP_DUP) begin
                    t_next = T;
                end else begin
                    t_next = Y;
                end
                y_next     = T;
                depth_next = depth + DEPTH_ONE;
                if (depth >= DEPTH_TWO) begin
                    spill_we = op_ok;
                    sp_next  = sp + SP_ONE;
                end
            end
            OP_DROP, OP_BINARY: begin
                t_next     = (stackOp == OP_DROP) ? Y : din;
                y_next     = refill;
                depth_next = depth - DEPTH_ONE;
                if (depth > DEPTH_TWO) begin
                    sp_next = sp_below;
                end
            end
            OP_UNARY: begin
                t_next = din;
            end
            OP_SWAP: begin
                t_next = Y;
                y_next = T;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            T         <= '0;
            Y         <= '0;
            depth     <= '0;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= over_err;
            underflow <= under_err;
            if (op_ok) begin
                T     <= t_next;
                Y     <= y_next;
                depth <= depth_next;
                sp    <= sp_next;
            end
        end
    end

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: directed scenarios plus a randomized
// run checked against a queue-based model of the stack.
import data_stack_pkg::*;

module tb_data_stack;

    localparam int DW  = 16;
    localparam int CAP = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    stackOp = OP_NOP;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] T, Y;
    logic [5:0]    depth;
    logic          empty, full, overflow, underflow;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    logic          exp_ov, exp_un;

    always #5 clk = ~clk;

    data_stack dut (
        .clk       (clk),
        .reset     (reset),
        .stackOp   (stackOp),
        .din       (din),
        .T         (T),
        .Y         (Y),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Reference: q[0] is the top of stack, plain list semantics.
    task automatic model_apply(input logic [2:0] op, input logic [DW-1:0] d);
        int need;
        logic [DW-1:0] a;
        exp_ov = 1'b0;
        exp_un = 1'b0;
        case (op)
            OP_NOP, OP_PUSH:            need = 0;
            OP_DROP, OP_UNARY, OP_DUP:  need = 1;
            default:                    need = 2;
        endcase
        if (q.size() < need) begin
            exp_un = 1'b1;
        end else if ((op == OP_PUSH || op == OP_DUP || op == OP_OVER) && q.size() == CAP) begin
            exp_ov = 1'b1;
        end else begin
            case (op)
                OP_PUSH:   q.push_front(d);
                OP_DROP:   a = q.pop_front();
                OP_UNARY:  q[0] = d;
                OP_BINARY: begin
                    a = q.pop_front();
                    a = q.pop_front();
                    q.push_front(d);
                end
                OP_DUP:    begin a = q[0]; q.push_front(a); end
                OP_SWAP:   begin a = q[0]; q[0] = q[1]; q[1] = a; end
                OP_OVER:   begin a = q[1]; q.push_front(a); end
                default:   ;
            endcase
        end
    endtask

    function automatic logic [DW-1:0] exp_t();
        return (q.size() >= 1) ? q[0] : '0;
    endfunction

    function automatic logic [DW-1:0] exp_y();
        return (q.size() >= 2) ? q[1] : '0;
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [DW-1:0] d);
        stackOp = op;
        din     = d;
        @(posedge clk);
        #1;
        model_apply(op, d);
        stackOp = OP_NOP;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        stackOp = OP_NOP;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (T !== '0 || Y !== '0 || depth !== 6'd0 || empty !== 1'b1 || full !== 1'b0
            || overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset T=%h Y=%h depth=%0d empty=%b full=%b ov=%b un=%b want 0 0 0 1 0 0 0",
                     T, Y, depth, empty, full, overflow, underflow);
        end
    endtask

    task automatic test_binary();
        do_reset();
        applyStimulus(OP_PUSH, 16'd5);
        applyStimulus(OP_PUSH, 16'd3);
        checks++;
        if (T !== 16'd3 || Y !== 16'd5 || depth !== 6'd2) begin
            failures++;
            $display("[TB] FAIL binary_setup T=%h Y=%h depth=%0d want 3 5 2", T, Y, depth);
        end
        applyStimulus(OP_BINARY, 16'd8);
        checks++;
        if (T !== 16'd8 || Y !== 16'd0 || depth !== 6'd1) begin
            failures++;
            $display("[TB] FAIL binary_result T=%h Y=%h depth=%0d want 8 0 1", T, Y, depth);
        end
    endtask

    task automatic test_push_drop();
        do_reset();
        for (int i = 1; i <= 6; i++) applyStimulus(OP_PUSH, 16'(i));
        checks++;
        if (T !== 16'd6 || Y !== 16'd5 || depth !== 6'd6) begin
            failures++;
            $display("[TB] FAIL push6 T=%h Y=%h depth=%0d want 6 5 6", T, Y, depth);
        end
        for (int i = 0; i < 4; i++) applyStimulus(OP_DROP, '0);
        checks++;
        if (T !== 16'd2 || Y !== 16'd1 || depth !== 6'd2) begin
            failures++;
            $display("[TB] FAIL drop4 T=%h Y=%h depth=%0d want 2 1 2", T, Y, depth);
        end
        for (int i = 0; i < 2; i++) applyStimulus(OP_DROP, '0);
        checks++;
        if (T !== 16'd0 || Y !== 16'd0 || depth !== 6'd0 || empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drop_all T=%h Y=%h depth=%0d empty=%b want 0 0 0 1", T, Y, depth, empty);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        applyStimulus(OP_DROP, '0);
        checks++;
        if (underflow !== 1'b1 || overflow !== 1'b0 || depth !== 6'd0) begin
            failures++;
            $display("[TB] FAIL underflow_empty un=%b ov=%b depth=%0d want 1 0 0", underflow, overflow, depth);
        end
        applyStimulus(OP_PUSH, 16'd4);
        checks++;
        if (underflow !== 1'b0 || T !== 16'd4) begin
            failures++;
            $display("[TB] FAIL underflow_pulse un=%b T=%h want 0 4", underflow, T);
        end
        applyStimulus(OP_SWAP, '0);
        checks++;
        if (underflow !== 1'b1 || T !== 16'd4 || Y !== 16'd0 || depth !== 6'd1) begin
            failures++;
            $display("[TB] FAIL underflow_swap un=%b T=%h Y=%h depth=%0d want 1 4 0 1", underflow, T, Y, depth);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < CAP; i++) applyStimulus(OP_PUSH, 16'(100 + i));
        checks++;
        if (full !== 1'b1 || depth !== 6'd18 || T !== 16'd117) begin
            failures++;
            $display("[TB] FAIL fill full=%b depth=%0d T=%h want 1 18 0075", full, depth, T);
        end
        applyStimulus(OP_PUSH, 16'hAAAA);
        checks++;
        if (overflow !== 1'b1 || underflow !== 1'b0 || T !== 16'd117 || Y !== 16'd116 || depth !== 6'd18) begin
            failures++;
            $display("[TB] FAIL overflow_push ov=%b un=%b T=%h Y=%h depth=%0d want 1 0 0075 0074 18",
                     overflow, underflow, T, Y, depth);
        end
        applyStimulus(OP_DUP, '0);
        checks++;
        if (overflow !== 1'b1 || depth !== 6'd18) begin
            failures++;
            $display("[TB] FAIL overflow_dup ov=%b depth=%0d want 1 18", overflow, depth);
        end
        applyStimulus(OP_DROP, '0);
        checks++;
        if (full !== 1'b0 || overflow !== 1'b0 || depth !== 6'd17 || T !== 16'd116 || Y !== 16'd115) begin
            failures++;
            $display("[TB] FAIL drop_from_full full=%b ov=%b depth=%0d T=%h Y=%h want 0 0 17 0074 0073",
                     full, overflow, depth, T, Y);
        end
        // Unwind everything to confirm the deepest spill slots read back in order.
        for (int i = 0; i < 15; i++) applyStimulus(OP_DROP, '0);
        checks++;
        if (depth !== 6'd2 || T !== 16'd101 || Y !== 16'd100) begin
            failures++;
            $display("[TB] FAIL unwind depth=%0d T=%h Y=%h want 2 0065 0064", depth, T, Y);
        end
    endtask

    task automatic test_dup_over_swap();
        do_reset();
        applyStimulus(OP_PUSH, 16'd9);
        applyStimulus(OP_PUSH, 16'd7);
        applyStimulus(OP_DUP, '0);
        checks++;
        if (T !== 16'd7 || Y !== 16'd7 || depth !== 6'd3) begin
            failures++;
            $display("[TB] FAIL dup T=%h Y=%h depth=%0d want 7 7 3", T, Y, depth);
        end
        applyStimulus(OP_OVER, '0);
        checks++;
        if (T !== 16'd7 || Y !== 16'd7 || depth !== 6'd4) begin
            failures++;
            $display("[TB] FAIL over T=%h Y=%h depth=%0d want 7 7 4", T, Y, depth);
        end
        applyStimulus(OP_PUSH, 16'd1);
        applyStimulus(OP_PUSH, 16'd2);
        applyStimulus(OP_SWAP, '0);
        checks++;
        if (T !== 16'd1 || Y !== 16'd2 || depth !== 6'd6) begin
            failures++;
            $display("[TB] FAIL swap T=%h Y=%h depth=%0d want 1 2 6", T, Y, depth);
        end
        applyStimulus(OP_UNARY, 16'h1234);
        checks++;
        if (T !== 16'h1234 || Y !== 16'd2 || depth !== 6'd6) begin
            failures++;
            $display("[TB] FAIL unary T=%h Y=%h depth=%0d want 1234 2 6", T, Y, depth);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 10; i++) applyStimulus(OP_PUSH, 16'(50 + i));
        reset   = 1'b1;
        stackOp = OP_PUSH;
        din     = 16'hBEEF;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        stackOp = OP_NOP;
        q.delete();
        checks++;
        if (depth !== 6'd0 || T !== '0 || Y !== '0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid depth=%0d T=%h Y=%h ov=%b un=%b want 0 0 0 0 0",
                     depth, T, Y, overflow, underflow);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        int r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            // Alternate push-heavy and pop-heavy phases so both limits get hit.
            if (((i / 300) % 2) == 0) begin
                op = (r < 45) ? OP_PUSH : (r < 55) ? OP_DUP : (r < 65) ? OP_OVER : 3'($urandom_range(0, 7));
            end else begin
                op = (r < 40) ? OP_DROP : (r < 60) ? OP_BINARY : 3'($urandom_range(0, 7));
            end
            applyStimulus(op, 16'($urandom));
            checks++;
            if (T !== exp_t() || Y !== exp_y() || depth !== 6'(q.size())
                || empty !== (q.size() == 0) || full !== (q.size() == CAP)
                || overflow !== exp_ov || underflow !== exp_un) begin
                failures++;
                $display("[TB] FAIL random[%0d] op=%0d T=%h/%h Y=%h/%h depth=%0d/%0d e=%b f=%b ov=%b/%b un=%b/%b (got/want)",
                         i, op, T, exp_t(), Y, exp_y(), depth, q.size(), empty, full,
                         overflow, exp_ov, underflow, exp_un);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_binary();
        test_push_drop();
        test_underflow();
        test_full();
        test_dup_over_swap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
